// File: rtl/bep_pkg.sv
// Shared definitions for the BEP thermostat frame path: frame geometry, field
// offsets and the controller state encoding.
package bep_pkg;

    localparam int unsigned BEP_FRAME_BITS = 192;
    localparam logic [31:0] BEP_PREAMBLE   = 32'hAAAAAAAA;

    // Frame is shifted in MSB first, so the first bit received lands at bit 191.
    localparam int unsigned BEP_PREAMBLE_LSB = 160;
    localparam int unsigned BEP_TYPE_LSB     = 144;

    typedef enum logic [2:0] {
        GAP     = 3'd0,
        IDLE    = 3'd1,
        RECEIVE = 3'd2,
        SETTLE  = 3'd3,
        CHECK   = 3'd4,
        VALID   = 3'd5,
        ERROR   = 3'd6
    } bep_state_t;

endpackage

// File: rtl/serial_sync_edge.sv
// Two-flop synchronisers for the raw serial pins plus rising-edge detect on the
// synchronised serial clock. Data is tapped at the same depth as the clock.
module serial_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_serial_clock,
    input  logic i_serial_data,
    output logic o_edge,
    output logic o_bit
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_dat_meta;
    logic r_dat_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_meta <= 1'b0;
            r_clk_sync <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_meta <= 1'b0;
            r_dat_sync <= 1'b0;
        end else begin
            r_clk_meta <= i_serial_clock;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_serial_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign o_edge = r_clk_sync & ~r_clk_prev;
    assign o_bit  = r_dat_sync;

endmodule

// File: rtl/bep_frame_controller.sv
// Sequences the BEP frame shift-register decoder: turns serial clock edges into
// shift strobes, frames transmissions, checks the preamble and hands frames off.
module bep_frame_controller
    import bep_pkg::*;
#(
    parameter int unsigned FRAME_BITS     = BEP_FRAME_BITS,
    parameter logic [31:0] PREAMBLE       = BEP_PREAMBLE,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_clock_in,
    input  logic        serial_data_in,
    output logic        dec_reset,
    output logic        dec_serial_clock,
    output logic        dec_serial_data,
    input  logic [31:0] dec_preamble,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        busy,
    output logic [7:0]  frame_count,
    output logic [7:0]  error_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);

    logic w_edge;
    logic w_bit;
    logic w_timed_out;

    bep_state_t    r_state;
    logic          r_dec_reset;
    logic          r_dec_sclk;
    logic          r_dec_sdata;
    logic          r_frame_valid;
    logic [7:0]    r_frame_count;
    logic [7:0]    r_error_count;
    logic [BW-1:0] r_bit_count;
    logic [TW-1:0] r_timeout;

    serial_sync_edge u_sync (
        .clock          (clock),
        .reset          (reset),
        .i_serial_clock (serial_clock_in),
        .i_serial_data  (serial_data_in),
        .o_edge         (w_edge),
        .o_bit          (w_bit)
    );

    // Line-idle timer: counts clocks since the last serial edge, saturating.
    always_ff @(posedge clock) begin
        if (reset || w_edge) begin
            r_timeout <= '0;
        end else if (r_timeout != TIMEOUT_MAX) begin
            r_timeout <= r_timeout + TW'(1);
        end
    end

    assign w_timed_out = (r_timeout == TIMEOUT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= GAP;
            r_dec_reset   <= 1'b1;
            r_dec_sclk    <= 1'b0;
            r_dec_sdata   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_count <= 8'd0;
            r_error_count <= 8'd0;
            r_bit_count   <= '0;
        end else begin
            r_dec_sclk <= 1'b0;
            unique case (r_state)
                GAP: begin
                    r_dec_reset <= 1'b1;
                    if (w_timed_out && !w_edge) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    // Release the decoder on the same edge as the first strobe.
                    if (w_edge) begin
                        r_state     <= RECEIVE;
                        r_dec_reset <= 1'b0;
                        r_dec_sclk  <= 1'b1;
                        r_dec_sdata <= w_bit;
                        r_bit_count <= BW'(1);
                    end
                end
                RECEIVE: begin
                    if (w_edge) begin
                        r_dec_sclk  <= 1'b1;
                        r_dec_sdata <= w_bit;
                        r_bit_count <= r_bit_count + BW'(1);
                        if (r_bit_count == LAST_BIT) begin
                            r_state <= SETTLE;
                        end
                    end else if (w_timed_out) begin
                        r_state     <= ERROR;
                        r_dec_reset <= 1'b1;
                    end
                end
                SETTLE: begin
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (dec_preamble == PREAMBLE) begin
                        r_state       <= VALID;
                        r_frame_valid <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                    end else begin
                        r_state     <= ERROR;
                        r_dec_reset <= 1'b1;
                    end
                end
                VALID: begin
                    if (frame_ready) begin
                        r_state       <= GAP;
                        r_frame_valid <= 1'b0;
                        r_dec_reset   <= 1'b1;
                    end
                end
                ERROR: begin
                    r_state     <= GAP;
                    r_dec_reset <= 1'b1;
                    if (r_error_count != 8'hFF) begin
                        r_error_count <= r_error_count + 8'd1;
                    end
                end
                default: begin
                    r_state       <= GAP;
                    r_dec_reset   <= 1'b1;
                    r_frame_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dec_reset        = r_dec_reset;
    assign dec_serial_clock = r_dec_sclk;
    assign dec_serial_data  = r_dec_sdata;
    assign frame_valid      = r_frame_valid;
    assign frame_count      = r_frame_count;
    assign error_count      = r_error_count;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_bep_frame_controller.sv
// Directed bench for bep_frame_controller: a full-size instance with a decoder
// model, plus a small instance used to drive the error counter to saturation.
module tb_bep_frame_controller;
    import bep_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        sclk, sdata, frame_ready;
    logic [31:0] dec_preamble;
    logic        dec_reset, dec_sclk, dec_sdata, frame_valid, busy;
    logic [7:0]  frame_count, error_count;

    logic        sclk2, sdata2, frame_ready2;
    logic [31:0] pre2;
    logic        dec_reset2, dec_sclk2, dec_sdata2, frame_valid2, busy2;
    logic [7:0]  frame_count2, error_count2;

    bep_frame_controller dut (
        .clock            (clock),
        .reset            (reset),
        .serial_clock_in  (sclk),
        .serial_data_in   (sdata),
        .dec_reset        (dec_reset),
        .dec_serial_clock (dec_sclk),
        .dec_serial_data  (dec_sdata),
        .dec_preamble     (dec_preamble),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .busy             (busy),
        .frame_count      (frame_count),
        .error_count      (error_count)
    );

    bep_frame_controller #(
        .FRAME_BITS     (8),
        .TIMEOUT_CYCLES (8)
    ) dut_small (
        .clock            (clock),
        .reset            (reset),
        .serial_clock_in  (sclk2),
        .serial_data_in   (sdata2),
        .dec_reset        (dec_reset2),
        .dec_serial_clock (dec_sclk2),
        .dec_serial_data  (dec_sdata2),
        .dec_preamble     (pre2),
        .frame_valid      (frame_valid2),
        .frame_ready      (frame_ready2),
        .busy             (busy2),
        .frame_count      (frame_count2),
        .error_count      (error_count2)
    );

    // Decoder model: MSB-first shift register cleared by dec_reset.
    logic [BEP_FRAME_BITS-1:0] r_dec_sr;
    always @(posedge clock) begin
        if (dec_reset) r_dec_sr <= '0;
        else if (dec_sclk) r_dec_sr <= {r_dec_sr[BEP_FRAME_BITS-2:0], dec_sdata};
    end
    assign dec_preamble = r_dec_sr[BEP_PREAMBLE_LSB +: 32];

    int   n_strobe = 0, n_strobe2 = 0, n_viol = 0, n_fv_rise = 0;
    int   cyc_n = 0, last_strobe_cyc = 0, fv_rise_cyc = 0;
    logic prev_sclk = 1'b0, prev_sclk2 = 1'b0, prev_fv = 1'b0;

    always @(negedge clock) begin
        cyc_n <= cyc_n + 1;
        if (dec_sclk) begin
            n_strobe        <= n_strobe + 1;
            last_strobe_cyc <= cyc_n;
        end
        if (dec_sclk2) n_strobe2 <= n_strobe2 + 1;
        if ((dec_sclk && (dec_reset || prev_sclk)) || (dec_sclk2 && (dec_reset2 || prev_sclk2)))
            n_viol <= n_viol + 1;
        if (frame_valid && !prev_fv) begin
            n_fv_rise   <= n_fv_rise + 1;
            fv_rise_cyc <= cyc_n;
        end
        prev_sclk  <= dec_sclk;
        prev_sclk2 <= dec_sclk2;
        prev_fv    <= frame_valid;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Serial clock period 16 system cycles, data set up 8 cycles before the rise.
    task automatic send_bit(input logic b);
        sdata = b;
        cyc(8);
        sclk = 1'b1;
        cyc(8);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [191:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(f[191-i]);
    endtask

    task automatic send_bit2(input logic b);
        sdata2 = b;
        cyc(1);
        sclk2 = 1'b1;
        cyc(2);
        sclk2 = 1'b0;
        cyc(1);
    endtask

    task automatic send_frame2(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) send_bit2(f[i]);
    endtask

    logic [191:0] good, bad;
    int s0, f0;

    initial begin
        good = {32'hAAAAAAAA, 16'hD391, {9{16'h5A3C}}};
        bad  = {32'hAAAAAAAB, 16'hD391, {9{16'h5A3C}}};
        reset = 1'b1;
        sclk = 1'b0; sdata = 1'b0; frame_ready = 1'b0;
        sclk2 = 1'b0; sdata2 = 1'b0; frame_ready2 = 1'b0; pre2 = 32'h0;
        cyc(3);
        check("rst dec_reset", 32'(dec_reset), 1);
        check("rst dec_sclk", 32'(dec_sclk), 0);
        check("rst frame_valid", 32'(frame_valid), 0);
        check("rst frame_count", 32'(frame_count), 0);
        check("rst error_count", 32'(error_count), 0);
        check("rst busy", 32'(busy), 1);
        reset = 1'b0;
        cyc(1000);
        check("gap busy early", 32'(busy), 1);
        cyc(30);
        check("idle busy", 32'(busy), 0);
        check("idle dec_reset", 32'(dec_reset), 1);

        // Good frame, held, extra edges during VALID, then accepted.
        s0 = n_strobe;
        send_frame(good, 192);
        check("good strobes", 32'(n_strobe - s0), 192);
        check("good valid", 32'(frame_valid), 1);
        check("valid latency", 32'(fv_rise_cyc - last_strobe_cyc), 2);
        check("good frame_count", 32'(frame_count), 1);
        check("good type field", 32'(r_dec_sr[BEP_TYPE_LSB +: 16]), 32'hD391);
        check("good payload", 32'(r_dec_sr[15:0]), 32'h5A3C);
        cyc(100);
        check("valid hold", 32'(frame_valid), 1);
        s0 = n_strobe;
        send_frame(good, 10);
        check("valid edges strobes", 32'(n_strobe - s0), 0);
        check("valid hold edges", 32'(frame_valid), 1);
        check("valid dec_reset", 32'(dec_reset), 0);
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
        check("accept valid", 32'(frame_valid), 0);
        check("accept dec_reset", 32'(dec_reset), 1);
        check("accept error_count", 32'(error_count), 0);

        // Bad preamble.
        cyc(1030);
        f0 = n_fv_rise;
        send_frame(bad, 192);
        cyc(10);
        check("bad no valid", 32'(n_fv_rise - f0), 0);
        check("bad error_count", 32'(error_count), 1);
        check("bad frame_count", 32'(frame_count), 1);
        check("bad busy", 32'(busy), 1);

        // Stalled frame, then a good frame.
        cyc(1030);
        send_frame(good, 100);
        cyc(1000);
        check("stall pending", 32'(error_count), 1);
        cyc(40);
        check("stall error_count", 32'(error_count), 2);
        check("stall idle", 32'(busy), 0);
        send_frame(good, 192);
        check("post stall valid", 32'(frame_valid), 1);
        check("post stall count", 32'(frame_count), 2);
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
        check("post stall accept", 32'(frame_valid), 0);

        // Reset mid-frame with edges continuing gap-free.
        cyc(1030);
        send_frame(good, 50);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        check("midrst frame_count", 32'(frame_count), 0);
        check("midrst error_count", 32'(error_count), 0);
        s0 = n_strobe;
        send_frame(good, 192);
        check("midrst strobes", 32'(n_strobe - s0), 0);
        check("midrst valid", 32'(frame_valid), 0);
        check("midrst busy", 32'(busy), 1);
        cyc(1030);
        check("midrst idle", 32'(busy), 0);
        s0 = n_strobe;
        send_frame(good, 192);
        check("midrst good strobes", 32'(n_strobe - s0), 192);
        check("midrst good count", 32'(frame_count), 1);
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;

        // Small instance: 256 bad frames saturate the error counter.
        for (int k = 0; k < 254; k++) begin
            send_frame2(8'h5A);
            cyc(12);
        end
        check("sat 254", 32'(error_count2), 254);
        send_frame2(8'hC3);
        cyc(12);
        check("sat 255", 32'(error_count2), 255);
        send_frame2(8'h3C);
        cyc(12);
        check("sat hold", 32'(error_count2), 255);
        check("sat strobes", 32'(n_strobe2), 2048);
        check("sat frame_count", 32'(frame_count2), 0);
        pre2 = 32'hAAAAAAAA;
        send_frame2(8'hA5);
        cyc(2);
        check("small valid", 32'(frame_valid2), 1);
        check("small frame_count", 32'(frame_count2), 1);
        s0 = n_strobe2;
        send_frame2(8'hFF);
        check("small valid edges", 32'(n_strobe2 - s0), 0);

        check("strobe rules", 32'(n_viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bep_frame_controller.md
Name: bep_frame_controller

Overview:
- Sequences the 192-bit BEP thermostat frame shift-register decoder.
- Synchronises the raw serial clock and data pins and converts serial clock rising edges into one-cycle shift strobes.
- Frames each transmission: clears the decoder between frames, times out stalled frames and checks the captured preamble.
- Presents a completed frame to downstream logic via a valid/ready handshake; keeps good/bad frame counters.

Parameters:
FRAME_BITS, 192, bits per transmission; the frame completes after this many strobes.
PREAMBLE, 32'hAAAAAAAA, required value of the captured preamble field.
TIMEOUT_CYCLES, 1024, system clocks without a serial edge that count as line idle or stall; minimum 4.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
serial_clock_in  input  1  raw asynchronous serial clock pin
serial_data_in  input  1  raw asynchronous serial data pin
dec_reset  output  1  drives decoder reset; registered
dec_serial_clock  output  1  one-cycle shift strobe to decoder; registered
dec_serial_data  output  1  bit accompanying the strobe; registered
dec_preamble  input  32  preamble field read back from the decoder
frame_valid  output  1  decoder holds a checked frame
frame_ready  input  1  consumer accepts the frame
busy  output  1  high in every state except IDLE
frame_count  output  8  good frames, wraps 255->0
error_count  output  8  bad or aborted frames, saturates at 255

Behaviour:
- Reset (already decided): reset reset, synchronous, active-high; clock clock.
- Reset values, also applied on reset mid-frame:
  - state GAP; dec_reset=1; dec_serial_clock=0; dec_serial_data=0; frame_valid=0.
  - frame_count=0, error_count=0, bit counter and timeout counter =0.
  - Synchroniser flops =0.
- Input path:
  - Both pins pass through a 2-flop synchroniser; the previous synced clock is also registered.
  - edge = sync_clk & ~prev_clk.
  - Data is taken from the synced data at the same stage, so clock and data see equal delay.
  - Raw rising edge to dec_serial_clock high is 3-4 cycles.
- Timeout counter:
  - Clears on every edge; otherwise increments and saturates at TIMEOUT_CYCLES-1.
  - Width is clog2(TIMEOUT_CYCLES).
- States:
  - GAP: dec_reset=1. Edges restart the timeout counter. When the counter reaches TIMEOUT_CYCLES-1 -> IDLE. This forces resync to an inter-frame gap after reset, error or accept.
  - IDLE: dec_reset=1, busy=0. On edge -> RECEIVE. On the same clock edge, registers load dec_reset=0, dec_serial_clock=1, dec_serial_data=bit and bit_count=1. The first bit is therefore never lost to decoder reset.
  - RECEIVE: dec_reset=0. Each edge gives a one-cycle strobe with its data bit, bit_count+1.
    - When the strobe for bit FRAME_BITS is issued -> SETTLE.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 first -> ERROR.
  - SETTLE: exactly one cycle, so the decoder completes its final shift -> CHECK.
  - CHECK: one cycle.
    - dec_preamble==PREAMBLE -> VALID, frame_count+1.
    - Otherwise -> ERROR.
  - VALID: frame_valid=1; dec_reset=0, so the decoder outputs stay stable.
    - Stay until frame_ready is sampled high. That same edge gives frame_valid=0, dec_reset=1 -> GAP.
    - frame_ready is ignored in all other states.
  - ERROR: one cycle, error_count+1 unless it is already 255 -> GAP.
- Edges arriving in SETTLE, CHECK, VALID or ERROR never produce strobes; GAP resynchronises afterwards.
- dec_serial_clock is never high for more than one consecutive cycle. It is never high while dec_reset=1.
- A frame with more than FRAME_BITS bits: the extra bits fall in SETTLE/CHECK/VALID and are dropped.

Decomposition:
- Shared package/include bep_pkg holds:
  - state encoding localparams: GAP, IDLE, RECEIVE, SETTLE, CHECK, VALID, ERROR;
  - BEP_FRAME_BITS=192 and BEP_PREAMBLE=32'hAAAAAAAA;
  - field offsets shared with the decoder.
- One sub-module: serial_sync_edge, containing the 2-flop synchronisers, prev-clock register and rising-edge detect. Outputs are edge and bit.

Test Plan:
- Reset, then 1024 quiet cycles -> dec_reset=1, frame_valid=0, counts 0, busy falls once the counter reaches 1023.
- Good 192-bit frame (preamble AAAAAAAA, type D391, serial clock period 16 cycles) -> exactly 192 strobes, frame_valid rises 2 cycles after the last strobe, frame_count=1. Hold frame_ready=0 for 100 cycles -> valid holds. frame_ready=1 -> valid=0 and dec_reset=1 next cycle.
- Frame with preamble AAAAAAAB -> frame_valid never rises, error_count=1, state back to GAP.
- Stop after 100 bits -> ERROR after 1024 quiet cycles, error_count=1. A following good frame is accepted, frame_count=1.
- Reset asserted at bit 50 with edges continuing gap-free -> no strobes and no frame until a 1024-cycle gap is seen.
- 256 back-to-back bad frames -> error_count=255 (saturated). Edges during VALID -> zero strobes.
